// File: rtl/counter_pkg.sv
// Shared definitions for the BCD counter, its sequencer and the display chain.
package counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_DONE  = 2'b11
   } state_e;

   localparam logic [15:0] BCD_MAX = 16'h9999;

   // True when every nibble of a 4-digit BCD word is in 0..9.
   function automatic logic bcd_valid(input logic [15:0] i_val);
      logic w_ok;
      w_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i_val[i*4 +: 4] > 4'd9) w_ok = 1'b0;
      end
      return w_ok;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: one-cycle tick every TICK_DIV enabled cycles; holds when disabled.
module tick_prescaler #(
   parameter int unsigned TICK_DIV = 5000000,
   parameter int unsigned DIV_W    = 23
) (
   input  logic i_clk,
   input  logic i_rst_a,
   input  logic i_en,
   input  logic i_sync_clr,
   output logic o_tick
);

   localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

   logic [DIV_W-1:0] r_cnt;

   assign o_tick = i_en && (r_cnt == LAST);

   always_ff @(posedge i_clk or negedge i_rst_a) begin
      if (!i_rst_a) begin
         r_cnt <= '0;
      end else if (i_sync_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/count_sequencer.sv
// Auto-count controller: turns button pulses and prescaler ticks into one-cycle inc/clr
// strobes for the BCD counter, stopping or reloading at the terminal count.
module count_sequencer
   import counter_pkg::*;
#(
   parameter int unsigned TICK_DIV = 5000000,
   parameter int unsigned DIV_W    = 23
) (
   input  logic        i_clk,
   input  logic        i_rst_a,
   input  logic        i_btn_run,
   input  logic        i_btn_step,
   input  logic        i_btn_clear,
   input  logic        i_auto_reload,
   input  logic [15:0] i_target_bcd,
   input  logic [15:0] i_count_bcd,
   output logic        o_inc,
   output logic        o_clr,
   output logic        o_running,
   output logic        o_done,
   output logic [1:0]  o_state
);

   state_e      r_state, w_state_d;
   logic        r_inc, w_inc_d;
   logic        r_clr, w_clr_d;
   logic [15:0] w_eff_tgt;
   logic        w_at_tgt;
   logic        w_busy;
   logic        w_tick;
   logic        w_pre_en;
   logic        w_pre_clr;

   assign w_eff_tgt = bcd_valid(i_target_bcd) ? i_target_bcd : BCD_MAX;
   assign w_at_tgt  = (i_count_bcd == w_eff_tgt) || (i_count_bcd == BCD_MAX);
   // A strobe still in flight means count_bcd is one cycle stale.
   assign w_busy    = r_inc | r_clr;

   // Freeze on the pausing/clearing edge so PAUSE resumes from the exact count.
   assign w_pre_en  = (r_state == ST_RUN) && !i_btn_run && !i_btn_clear;
   assign w_pre_clr = i_btn_clear ||
                      (i_btn_run && ((r_state == ST_IDLE) || (r_state == ST_DONE)));

   tick_prescaler #(
      .TICK_DIV (TICK_DIV),
      .DIV_W    (DIV_W)
   ) u_prescaler (
      .i_clk      (i_clk),
      .i_rst_a    (i_rst_a),
      .i_en       (w_pre_en),
      .i_sync_clr (w_pre_clr),
      .o_tick     (w_tick)
   );

   always_comb begin
      w_state_d = r_state;
      w_inc_d   = 1'b0;
      w_clr_d   = 1'b0;
      if (i_btn_clear) begin
         w_clr_d   = 1'b1;
         w_state_d = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE, ST_PAUSE: begin
               if (i_btn_run) begin
                  w_state_d = ST_RUN;
               end else if (i_btn_step && !w_at_tgt && !w_busy) begin
                  w_inc_d = 1'b1;
               end
            end
            ST_RUN: begin
               if (i_btn_run) begin
                  w_state_d = ST_PAUSE;
               end else if (w_tick) begin
                  if (!w_at_tgt)          w_inc_d   = 1'b1;
                  else if (i_auto_reload) w_clr_d   = 1'b1;
                  else                    w_state_d = ST_DONE;
               end
            end
            ST_DONE: begin
               if (i_btn_run) begin
                  w_clr_d   = 1'b1;
                  w_state_d = ST_RUN;
               end
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_a) begin
      if (!i_rst_a) begin
         r_state <= ST_IDLE;
         r_inc   <= 1'b0;
         r_clr   <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_inc   <= w_inc_d;
         r_clr   <= w_clr_d;
      end
   end

   assign o_inc     = r_inc;
   assign o_clr     = r_clr;
   assign o_running = (r_state == ST_RUN);
   assign o_done    = (r_state == ST_DONE);
   assign o_state   = r_state;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with a behavioural BCD counter closing the feedback loop.
module tb_count_sequencer;

   logic        clk = 1'b0;
   logic        rst_a;
   logic        btn_run, btn_step, btn_clear, auto_reload;
   logic [15:0] target, count;
   logic        inc, clr, running, done;
   logic [1:0]  state;
   logic        ld_req;
   logic [15:0] ld_val;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   count_sequencer #(
      .TICK_DIV (4),
      .DIV_W    (3)
   ) dut (
      .i_clk         (clk),
      .i_rst_a       (rst_a),
      .i_btn_run     (btn_run),
      .i_btn_step    (btn_step),
      .i_btn_clear   (btn_clear),
      .i_auto_reload (auto_reload),
      .i_target_bcd  (target),
      .i_count_bcd   (count),
      .o_inc         (inc),
      .o_clr         (clr),
      .o_running     (running),
      .o_done        (done),
      .o_state       (state)
   );

   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (r[i*4 +: 4] == 4'd9) r[i*4 +: 4] = 4'd0;
            else begin
               r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Counter datapath model: registers inc/clr, so count moves one cycle after a strobe.
   always @(posedge clk) begin
      if (ld_req)   count <= ld_val;
      else if (clr) count <= 16'h0000;
      else if (inc) count <= bcd_inc(count);
   end

   task automatic pulse(input logic r, input logic s, input logic c);
      btn_run = r; btn_step = s; btn_clear = c;
      @(negedge clk);
      btn_run = 1'b0; btn_step = 1'b0; btn_clear = 1'b0;
   endtask

   task automatic load(input logic [15:0] v);
      ld_val = v; ld_req = 1'b1;
      @(negedge clk);
      ld_req = 1'b0;
   endtask

   task automatic do_clear();
      pulse(1'b0, 1'b0, 1'b1);
      @(negedge clk);
   endtask

   task automatic test_reset();
      #12;
      checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
      checks++; if (inc !== 1'b0) begin errors++; $display("FAIL reset_inc got %b want 0", inc); end
      checks++; if (clr !== 1'b0) begin errors++; $display("FAIL reset_clr got %b want 0", clr); end
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b want 0", running); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      @(negedge clk);
      rst_a = 1'b1; ld_req = 1'b0;
   endtask

   task automatic test_run_done();
      int first, n, bad;
      first = 0; n = 0; bad = 0;
      pulse(1'b1, 1'b0, 1'b0);
      checks++; if (state !== 2'b01) begin errors++; $display("FAIL run_enter got %0d want 1", state); end
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL run_running got %b want 1", running); end
      for (int c = 1; c <= 28; c++) begin
         @(negedge clk);
         if (inc) begin
            n++;
            if (first == 0) first = c;
            if (c % 4 != 0) bad++;
         end
         if (inc && clr) bad++;
      end
      checks++; if (first != 4) begin errors++; $display("FAIL run_first_inc got cycle %0d want 4", first); end
      checks++; if (n != 5) begin errors++; $display("FAIL run_inc_count got %0d want 5", n); end
      checks++; if (bad != 0) begin errors++; $display("FAIL run_inc_spacing got %0d bad want 0", bad); end
      checks++; if (state !== 2'b11) begin errors++; $display("FAIL run_done_state got %0d want 3", state); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL run_done_flag got %b want 1", done); end
      checks++; if (count !== 16'h0005) begin errors++; $display("FAIL run_count got %h want 0005", count); end
      pulse(1'b0, 1'b1, 1'b0);
      checks++; if (inc !== 1'b0) begin errors++; $display("FAIL done_step_inc got %b want 0", inc); end
      checks++; if (state !== 2'b11) begin errors++; $display("FAIL done_step_state got %0d want 3", state); end
   endtask

   task automatic test_reload();
      int n, clr_cyc, last, bad;
      n = 0; clr_cyc = 0; last = 0; bad = 0;
      do_clear();
      auto_reload = 1'b1;
      pulse(1'b1, 1'b0, 1'b0);
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (inc) begin n++; last = c; end
         if (clr && clr_cyc == 0) begin
            clr_cyc = c;
            if (state !== 2'b01) bad++;
         end
         if (inc && clr) bad++;
      end
      checks++; if (clr_cyc != 24) begin errors++; $display("FAIL reload_clr got cycle %0d want 24", clr_cyc); end
      checks++; if (n != 6) begin errors++; $display("FAIL reload_inc_count got %0d want 6", n); end
      checks++; if (last != 28) begin errors++; $display("FAIL reload_resume got cycle %0d want 28", last); end
      checks++; if (bad != 0) begin errors++; $display("FAIL reload_state got %0d bad want 0", bad); end
      auto_reload = 1'b0;
      pulse(1'b1, 1'b0, 1'b0);
      do_clear();
   endtask

   task automatic test_step();
      load(16'h0042);
      for (int k = 0; k < 3; k++) begin
         pulse(1'b0, 1'b1, 1'b0);
         checks++; if (inc !== 1'b1) begin errors++; $display("FAIL step_inc[%0d] got %b want 1", k, inc); end
         @(negedge clk);
         checks++; if (inc !== 1'b0) begin errors++; $display("FAIL step_single[%0d] got %b want 0", k, inc); end
         @(negedge clk);
      end
      checks++; if (count !== 16'h0045) begin errors++; $display("FAIL step_count got %h want 0045", count); end
   endtask

   task automatic test_back_to_back();
      pulse(1'b0, 1'b1, 1'b0);
      pulse(1'b0, 1'b1, 1'b0);
      checks++; if (inc !== 1'b0) begin errors++; $display("FAIL b2b_second_inc got %b want 0", inc); end
      @(negedge clk);
      @(negedge clk);
      checks++; if (count !== 16'h0046) begin errors++; $display("FAIL b2b_count got %h want 0046", count); end
      pulse(1'b1, 1'b1, 1'b0);
      checks++; if (state !== 2'b01) begin errors++; $display("FAIL runstep_state got %0d want 1", state); end
      checks++; if (inc !== 1'b0) begin errors++; $display("FAIL runstep_inc got %b want 0", inc); end
      pulse(1'b1, 1'b0, 1'b0);
      do_clear();
   endtask

   task automatic test_invalid_target();
      int bad;
      bad = 0;
      target = 16'h12A4;
      load(16'h9998);
      pulse(1'b0, 1'b1, 1'b0);
      checks++; if (inc !== 1'b1) begin errors++; $display("FAIL max_step_inc got %b want 1", inc); end
      @(negedge clk);
      @(negedge clk);
      checks++; if (count !== 16'h9999) begin errors++; $display("FAIL max_count got %h want 9999", count); end
      pulse(1'b0, 1'b1, 1'b0);
      checks++; if (inc !== 1'b0) begin errors++; $display("FAIL max_step_blocked got %b want 0", inc); end
      pulse(1'b1, 1'b0, 1'b0);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (inc) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL max_run_inc got %0d incs want 0", bad); end
      checks++; if (state !== 2'b11) begin errors++; $display("FAIL max_run_state got %0d want 3", state); end
      do_clear();
      target = 16'h0005;
   endtask

   task automatic test_pause_resume();
      int bad, first;
      bad = 0; first = 0;
      pulse(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      pulse(1'b1, 1'b0, 1'b0);
      checks++; if (state !== 2'b10) begin errors++; $display("FAIL pause_state got %0d want 2", state); end
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL pause_running got %b want 0", running); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (inc) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL pause_inc got %0d incs want 0", bad); end
      pulse(1'b1, 1'b0, 1'b0);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (inc && first == 0) first = c;
      end
      checks++; if (first != 2) begin errors++; $display("FAIL resume_first_inc got cycle %0d want 2", first); end
      do_clear();
   endtask

   task automatic test_done_restart_clear();
      target = 16'h0001;
      pulse(1'b1, 1'b0, 1'b0);
      repeat (10) @(negedge clk);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL tgt1_done got %b want 1", done); end
      pulse(1'b1, 1'b0, 1'b0);
      checks++; if (clr !== 1'b1) begin errors++; $display("FAIL restart_clr got %b want 1", clr); end
      checks++; if (state !== 2'b01) begin errors++; $display("FAIL restart_state got %0d want 1", state); end
      repeat (10) @(negedge clk);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL restart_done got %b want 1", done); end
      pulse(1'b1, 1'b0, 1'b1);
      checks++; if (clr !== 1'b1) begin errors++; $display("FAIL clrprio_clr got %b want 1", clr); end
      checks++; if (state !== 2'b00) begin errors++; $display("FAIL clrprio_state got %0d want 0", state); end
      checks++; if (inc !== 1'b0) begin errors++; $display("FAIL clrprio_inc got %b want 0", inc); end
      @(negedge clk);
      target = 16'h0005;
   endtask

   task automatic test_async_reset();
      pulse(1'b0, 1'b1, 1'b0);
      checks++; if (inc !== 1'b1) begin errors++; $display("FAIL arst_pre_inc got %b want 1", inc); end
      #1 rst_a = 1'b0;
      #1;
      checks++; if (inc !== 1'b0) begin errors++; $display("FAIL arst_inc got %b want 0", inc); end
      checks++; if (state !== 2'b00) begin errors++; $display("FAIL arst_state got %0d want 0", state); end
      checks++; if (clr !== 1'b0) begin errors++; $display("FAIL arst_clr got %b want 0", clr); end
      @(negedge clk);
      rst_a = 1'b1;
   endtask

   initial begin
      rst_a = 1'b0;
      btn_run = 1'b0; btn_step = 1'b0; btn_clear = 1'b0;
      auto_reload = 1'b0;
      target = 16'h0005;
      ld_val = 16'h0000; ld_req = 1'b1;
      test_reset();
      test_run_done();
      test_reload();
      test_step();
      test_back_to_back();
      test_invalid_target();
      test_pause_resume();
      test_done_restart_clear();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
Auto-count controller for the 4-digit BCD counter datapath and its 7-segment display chain. Takes debounced single-cycle button pulses and a BCD target value, and issues one-cycle inc/clr strobes to the counter at a programmable rate. It supports run/pause, single-step, terminal-count stop or auto-reload, and guards the datapath against stepping past 9999.

Parameters:
TICK_DIV, 5000000, clk cycles between auto-increments in RUN (10 Hz at 50 MHz); legal range is 2 or more.
DIV_W, 23, prescaler counter width; must satisfy 2^DIV_W >= TICK_DIV.

Ports:
clk  input  1  system clock, rising edge
rst_a  input  1  asynchronous, active-low reset
btn_run  input  1  debounced 1-cycle pulse; toggles run/pause, restarts from DONE
btn_step  input  1  debounced 1-cycle pulse; single increment when not running
btn_clear  input  1  debounced 1-cycle pulse; clears counter and returns to IDLE
auto_reload  input  1  1 = wrap to 0000 at target and keep running; 0 = stop in DONE
target_bcd  input  16  terminal count, 4 BCD digits {thous,hund,tens,units}
count_bcd  input  16  current counter value, fed back from the datapath, same digit order
inc  output  1  1-cycle increment strobe to the counter
clr  output  1  1-cycle clear strobe to the counter
running  output  1  high while state==RUN
done  output  1  high while state==DONE
state  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11

Behaviour:
- Reset (rst_a low, async): state=IDLE, inc=0, clr=0, prescaler=0, running=0, done=0.
- All outputs are registered. A strobe appears the cycle after its triggering event or tick.
- inc and clr are never high in the same cycle. Neither strobe is ever held for more than 1 cycle.
- Effective target: target_bcd, but 16'h9999 if any target digit is greater than 9.
- at_tgt: asserted when count_bcd == effective target, or when count_bcd == 16'h9999. This prevents datapath overflow.
- Prescaler:
  - Counts only in RUN.
  - Tick when the count reaches TICK_DIV-1; the count then returns to 0.
  - Holds its value in PAUSE.
  - Zeroed on entry to RUN from IDLE or DONE, and on clear.
- Event priority in one cycle: btn_clear > btn_run > btn_step > tick.
- btn_clear, in any state: clr=1 next cycle, state goes to IDLE, prescaler=0.
- IDLE:
  - btn_run goes to RUN.
  - btn_step issues inc if !at_tgt, and is ignored if at_tgt.
- RUN:
  - btn_run goes to PAUSE.
  - On a tick with !at_tgt: inc.
  - On a tick with at_tgt and auto_reload=1: clr, state stays RUN.
  - On a tick with at_tgt and auto_reload=0: go to DONE, no strobe.
  - btn_step is ignored.
- PAUSE:
  - btn_run goes to RUN, keeping the prescaler value.
  - btn_step behaves as in IDLE.
- DONE:
  - btn_run issues clr and goes to RUN with prescaler=0.
  - btn_step is ignored.
  - target_bcd changes are not re-evaluated until the next RUN tick.
- Feedback timing: count_bcd updates 1 cycle after inc. TICK_DIV >= 2 guarantees at_tgt is evaluated on the updated value.
- Step pulses closer than 2 cycles apart: the second pulse is ignored while an inc is in flight. A 1-bit pending flag implements this.
- Mid-run reset: async; all strobes drop immediately and no partial strobe is emitted.

Decomposition:
- Shared package counter_pkg:
  - state encoding constants ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE.
  - BCD_MAX = 16'h9999.
  - BCD digit-validity function, also usable by the counter and display blocks.
- One sub-module, tick_prescaler (params TICK_DIV, DIV_W):
  - inputs: clk, rst_a, en, sync_clr.
  - output: tick.
- The FSM and at_tgt compare stay in count_sequencer.

Test Plan:
- TICK_DIV=4, target 0005, auto_reload=0, btn_run at count 0000 -> inc every 4 cycles; count reaches 0005; next tick enters DONE with no inc; done=1.
- Same setup but auto_reload=1 -> at 0005 the tick issues clr instead of inc; count goes to 0000 and state stays RUN; inc resumes 4 cycles later.
- IDLE, count 0042, three btn_step pulses 3 cycles apart -> three single-cycle inc strobes, count 0045; btn_step on the same cycle as btn_run -> only the RUN transition, no inc.
- Target 12A4 (invalid digit), count stepped to 9999 -> further steps ignored and the RUN tick goes to DONE; no inc ever issued at 9999.
- RUN, btn_run at prescaler=2 -> PAUSE; btn_run again -> first inc after 2 more cycles, not 4.
- btn_clear together with btn_run in DONE -> clr, IDLE; assert rst_a low during an inc cycle -> inc=0 immediately, state=IDLE.
